// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and types for the 8x8 fifo read path
package fifo_pkg;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 3;
  localparam int FIFO_DEPTH = 8;
  typedef logic [DATA_W-1:0] byte_t;
endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - circular skid queue absorbing the fifo read latency
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 2,
  localparam int PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int OCC_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [OCC_W-1:0]  occ,
  output logic              valid
);
  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [OCC_W-1:0]  occ_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Capture and pop may coincide; occupancy then stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      occ_q <= occ_q + OCC_W'(wr_en) - OCC_W'(rd_en);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign occ     = occ_q;
  assign valid   = (occ_q != '0);
endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - pops the fifo under credit control and streams bytes out
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drain_en,
  input  logic              empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              RDEN,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  rd_count,
  output logic              busy
);
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  logic [OCC_W-1:0] occ;
  logic             inflight;
  logic             pop;
  logic [CNT_W-1:0] count_q;

  assign pop = m_valid && m_ready;

  // Credit counts the in-flight byte and frees the slot being popped this cycle.
  always_comb begin
    RDEN = !rst && drain_en && !empty &&
           ((int'(occ) + int'(inflight) - int'(pop)) < BUF_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      count_q  <= '0;
    end else begin
      inflight <= RDEN;
      if (pop) count_q <= count_q + 1'b1;
    end
  end

  stream_skid_buf #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight),
    .wr_data (fifo_data),
    .rd_en   (pop),
    .rd_data (m_data),
    .occ     (occ),
    .valid   (m_valid)
  );

  assign rd_count = count_q;
  assign busy     = (occ != '0) || inflight;

  a_no_pop_empty: assert property (@(posedge clk) !(RDEN && empty));
  a_occ_bound:    assert property (@(posedge clk) disable iff (rst)
                                   (int'(occ) + int'(inflight)) <= BUF_DEPTH);
  a_hold:         assert property (@(posedge clk) disable iff (rst)
                                   m_valid && !m_ready |=> $stable(m_data));
  a_known:        assert property (@(posedge clk) disable iff (rst)
                                   m_valid |-> !$isunknown(m_data));
endmodule
